a51_stream_xor: RTL and testbench
=================================

# a51_stream_xor

Keystream combiner for the A5/1 cipher datapath. It latches a 224-bit message (plaintext or ciphertext) from the data store and XORs it, MSB first, with the A5/1 keystream, one bit per valid cycle, during the generator's output stage. It then presents the result for byte-wise readback by the display/readout logic. Encryption and decryption are the same operation: running the output back through the block with the same key and frame restores the input.

## Interface

Parameters:
- MSG_BITS, 224, message length in bits; multiple of 8, at most 255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle request; latches data_in and begins a run.
- data_in  input  MSG_BITS  message word from the data store register.
- ks_bit  input  1  keystream bit, the A5/1 output bit.
- ks_valid  input  1  ks_bit is valid this cycle; driven by the output-stage indicator.
- out_index  input  5  byte index for readback, 0..MSG_BITS/8-1.
- out_byte  output  8  work[8*out_index+7 : 8*out_index]; 8'h00 when out_index >= MSG_BITS/8.
- result  output  MSG_BITS  full work register.
- bit_count  output  8  number of keystream bits consumed in the current or last run.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (level, not pulse).

## Operation

- State: work register (MSG_BITS), bit_count (8), FSM {IDLE, RUN, DONE}.
- Reset, asynchronous: FSM=IDLE, work=0, bit_count=0. Consequently busy=0, done=0, result=0, out_byte=0.
- IDLE:
  - start=1 gives work<=data_in, bit_count<=0, and moves to RUN.
  - ks_valid is ignored.
- RUN, on each edge with ks_valid=1:
  - work[MSG_BITS-1-bit_count] <= work[MSG_BITS-1-bit_count] ^ ks_bit.
  - bit_count <= bit_count+1.
  - If bit_count == MSG_BITS-1, move to DONE.
- RUN with ks_valid=0: hold all state. This is a stall and has no timeout.
- RUN with start=1: start is ignored and the run continues.
- DONE:
  - work and bit_count (=MSG_BITS) hold.
  - ks_valid is ignored.
  - start=1 behaves exactly as in IDLE: relatch data_in, clear bit_count, move to RUN.
- Keystream ordering: the first valid bit combines with data bit MSG_BITS-1, and the last with bit 0.
- Readout paths: out_byte and result are combinational from work. They are readable in every state; they are meaningful as the cipher result only while done=1.
- bit_count never exceeds MSG_BITS and never wraps.

## Timing

- start sampled at edge E0: busy=1 after E0. A ks_valid asserted in the same cycle as start is not consumed.
- Continuous ks_valid from the cycle after start: bits are consumed at edges E1..E224. done=1 and busy=0 after E224.
- Total latency is MSG_BITS valid cycles plus 1 edge for the start. Each stall cycle adds exactly one cycle.
- out_byte follows out_index combinationally with zero latency. It updates in the same cycle as the work-register edge.
- Reset asserted mid-run:
  - Outputs clear immediately, asynchronously, without waiting for clk.
  - After reset deasserts, the block is in IDLE and requires a new start.
- Reset and start together: reset wins and the block is in IDLE.

## Test plan

- Reset: assert reset with clk stopped -> busy=0, done=0, bit_count=0, result=0, out_byte=8'h00 for every out_index.
- All-ones keystream: data_in=0, start, then ks_valid=1 and ks_bit=1 continuously -> done rises exactly 224 edges after start; result all ones; out_byte=8'hFF for out_index=5; bit_count=224.
- Identity: data_in=224'h0123...CDEF pattern, ks_bit=0 -> result equals data_in; out_byte(0)=data_in[7:0]; out_byte(27)=data_in[223:216]; out_index=28..31 -> 8'h00.
- Stall: ks_valid toggled 1,0,1,0 with ks_bit=1 -> bit_count holds on low cycles; done 448 cycles after start; result all ones.
- Involution: encrypt a random data_in with an LFSR keystream (seed 19'h5A5A5), then start again with the result as data_in and the same keystream -> result equals the original data_in.
- Control corners:
  - Reset at bit_count=100 -> immediate IDLE with all zeros.
  - start pulsed at bit_count=50 -> ignored, and the run completes with the original data.
  - start in DONE -> new run, bit_count=0.

Source files
------------

// File: rtl/a51_stream_xor.sv
`default_nettype none
// a51_stream_xor: XORs a latched message with the A5/1 keystream, MSB first,
// one bit per valid keystream cycle; result readable whole or byte-wise.
module a51_stream_xor #(
  parameter int MSG_BITS = 224
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MSG_BITS-1:0] data_in,
  input  logic                ks_bit,
  input  logic                ks_valid,
  input  logic [4:0]          out_index,
  output logic [7:0]          out_byte,
  output logic [MSG_BITS-1:0] result,
  output logic [7:0]          bit_count,
  output logic                busy,
  output logic                done
);

  localparam int         IW     = $clog2(MSG_BITS);
  localparam int         NBYTES = MSG_BITS / 8;
  localparam logic [7:0] LAST   = 8'(MSG_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [MSG_BITS-1:0]   work_q, work_d;
  logic [7:0]            bit_count_q, bit_count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [IW-1:0]         bit_idx;
  logic [MSG_BITS-1:0]   work_shifted;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    bit_count_d = bit_count_q;
    // First consumed bit lands on the MSB, the last on bit 0.
    bit_idx     = IW'(LAST - bit_count_q);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          work_d      = data_in;
          bit_count_d = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (ks_valid) begin
          work_d[bit_idx] = work_q[bit_idx] ^ ks_bit;
          bit_count_d     = bit_count_q + 8'd1;
          if (bit_count_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      bit_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      bit_count_q <= bit_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Shifting instead of part-selecting keeps indices past the message in range.
  always_comb begin
    work_shifted = work_q >> {out_index, 3'b000};
    out_byte     = ({3'b000, out_index} < 8'(NBYTES)) ? work_shifted[7:0] : 8'h00;
  end

  assign result    = work_q;
  assign bit_count = bit_count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_a51_stream_xor.sv
`default_nettype none
// tb_a51_stream_xor: randomized self-checking bench against a keystream-queue model.
module tb_a51_stream_xor;

  localparam int MSG_BITS = 224;
  localparam int NBYTES   = MSG_BITS / 8;

  logic                clk;
  logic                clk_en;
  logic                reset;
  logic                start;
  logic [MSG_BITS-1:0] data_in;
  logic                ks_bit;
  logic                ks_valid;
  logic [4:0]          out_index;
  logic [7:0]          out_byte;
  logic [MSG_BITS-1:0] result;
  logic [7:0]          bit_count;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: latched message plus the list of consumed keystream bits.
  logic [MSG_BITS-1:0] m_data;
  bit                  m_q[$];
  bit                  m_run;
  bit                  m_done;

  logic ks_arr [MSG_BITS];

  a51_stream_xor #(.MSG_BITS(MSG_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .ks_bit    (ks_bit),
    .ks_valid  (ks_valid),
    .out_index (out_index),
    .out_byte  (out_byte),
    .result    (result),
    .bit_count (bit_count),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [MSG_BITS-1:0] exp_work();
    logic [MSG_BITS-1:0] r;
    r = m_data;
    for (int i = 0; i < m_q.size(); i++) r[MSG_BITS-1-i] = r[MSG_BITS-1-i] ^ m_q[i];
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int idx);
    logic [MSG_BITS-1:0] w;
    w = exp_work();
    if (idx < NBYTES) return w[idx*8 +: 8];
    return 8'h00;
  endfunction

  task automatic model_clear();
    m_data = '0;
    m_q.delete();
    m_run  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int idx;
    idx       = $urandom_range(0, 31);
    out_index = 5'(idx);
    #0.1;
    chk({tag, ".busy"},  256'(busy),      256'(m_run));
    chk({tag, ".done"},  256'(done),      256'(m_done));
    chk({tag, ".count"}, 256'(bit_count), 256'(m_q.size()));
    chk({tag, ".result"}, 256'(result),   256'(exp_work()));
    chk({tag, ".byte"},  256'(out_byte),  256'(exp_byte(idx)));
  endtask

  // One clock edge with the given inputs; model follows the functional rules.
  task automatic tick(input logic v, input logic b, input logic s, input string tag);
    ks_valid = v;
    ks_bit   = b;
    start    = s;
    @(posedge clk);
    if (!m_run && s) begin
      m_data = data_in;
      m_q.delete();
      m_run  = 1'b1;
      m_done = 1'b0;
    end else if (m_run && v) begin
      m_q.push_back(b);
      if (m_q.size() == MSG_BITS) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
    #1;
    start    = 1'b0;
    ks_valid = 1'b0;
    check_all(tag);
  endtask

  task automatic gen_lfsr(input logic [18:0] seed);
    logic [18:0] r;
    r = seed;
    for (int i = 0; i < MSG_BITS; i++) begin
      ks_arr[i] = r[18];
      r = {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13]};
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < MSG_BITS; i += 32) data_in[i +: 32] = $urandom;
  endtask

  // Feeds the whole LFSR stream with random stalls; returns edges used.
  task automatic run_lfsr(input string tag, output int edges);
    int k;
    k = 0;
    edges = 0;
    while (k < MSG_BITS && edges < 2000) begin
      if ($urandom_range(0, 3) != 0) begin
        tick(1'b1, ks_arr[k], 1'b0, tag);
        k++;
      end else begin
        tick(1'b0, $urandom_range(0, 1) == 1, 1'b0, tag);
      end
      edges++;
    end
  endtask

  initial begin
    logic [MSG_BITS-1:0] orig;
    logic [MSG_BITS-1:0] ones;
    int                  cnt;
    int                  edges;

    clk_en    = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    data_in   = '0;
    ks_bit    = 1'b0;
    ks_valid  = 1'b0;
    out_index = '0;
    model_clear();
    ones = '1;

    // Reset with the clock stopped: every output byte must read zero.
    #2;
    for (int i = 0; i < 32; i++) begin
      out_index = 5'(i);
      #1;
      chk("rst_byte", 256'(out_byte), 256'h0);
    end
    check_all("rst");

    clk_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1'b1, 1'b1, 1'b0, "idle_ks_ignored");

    // All-ones keystream on a zero message.
    data_in = '0;
    tick(1'b1, 1'b1, 1'b1, "ones_start");
    cnt = 0;
    while (!done && cnt < 300) begin
      tick(1'b1, 1'b1, 1'b0, "ones_run");
      cnt++;
    end
    chk("ones_latency", 256'(cnt), 256'd224);
    chk("ones_result", 256'(result), 256'(ones));
    out_index = 5'd5;
    #1;
    chk("ones_byte5", 256'(out_byte), 256'hFF);
    chk("ones_count", 256'(bit_count), 256'd224);
    tick(1'b1, 1'b0, 1'b0, "done_hold");

    // Identity with a zero keystream.
    data_in = 224'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF01234567;
    tick(1'b0, 1'b0, 1'b1, "id_start");
    for (int i = 0; i < MSG_BITS; i++) tick(1'b1, 1'b0, 1'b0, "id_run");
    chk("id_result", 256'(result), 256'(data_in));
    out_index = 5'd0;
    #1;
    chk("id_byte0", 256'(out_byte), 256'(data_in[7:0]));
    out_index = 5'd27;
    #1;
    chk("id_byte27", 256'(out_byte), 256'(data_in[223:216]));
    for (int i = 28; i < 32; i++) begin
      out_index = 5'(i);
      #1;
      chk("id_byte_oob", 256'(out_byte), 256'h0);
    end

    // Stall pattern: valid in the start cycle is not consumed, then 0,1,0,1...
    data_in = '0;
    tick(1'b1, 1'b1, 1'b1, "stall_start");
    cnt = 0;
    while (!done && cnt < 600) begin
      tick(cnt[0], 1'b1, 1'b0, "stall_run");
      cnt++;
    end
    chk("stall_latency", 256'(cnt), 256'd448);
    chk("stall_result", 256'(result), 256'(ones));

    // Involution with an LFSR keystream.
    gen_lfsr(19'h5A5A5);
    rand_data();
    orig = data_in;
    tick(1'b0, 1'b0, 1'b1, "enc_start");
    run_lfsr("enc", edges);
    chk("enc_done", 256'(done), 256'd1);
    data_in = result;
    tick(1'b0, 1'b0, 1'b1, "dec_start");
    run_lfsr("dec", edges);
    chk("involution", 256'(result), 256'(orig));

    // Asynchronous reset at bit_count=100.
    rand_data();
    tick(1'b0, 1'b0, 1'b1, "rst_mid_start");
    for (int i = 0; i < 100; i++) tick(1'b1, $urandom_range(0, 1) == 1, 1'b0, "rst_mid_run");
    chk("rst_mid_count", 256'(bit_count), 256'd100);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all("rst_async");
    // Reset held over an edge with start asserted: reset wins.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_all("rst_vs_start");
    reset = 1'b0;
    tick(1'b1, 1'b1, 1'b0, "post_rst_idle");

    // start during RUN at bit_count=50 is ignored.
    rand_data();
    orig = data_in;
    tick(1'b0, 1'b0, 1'b1, "mid_start_begin");
    for (int i = 0; i < 50; i++) tick(1'b1, ks_arr[i], 1'b0, "mid_start_run");
    rand_data();
    tick(1'b1, ks_arr[50], 1'b1, "mid_start_pulse");
    for (int i = 51; i < MSG_BITS; i++) tick(1'b1, ks_arr[i], 1'b0, "mid_start_rest");
    chk("mid_start_done", 256'(done), 256'd1);
    data_in = result;
    tick(1'b0, 1'b0, 1'b1, "done_restart");
    chk("done_restart_cnt", 256'(bit_count), 256'd0);
    chk("done_restart_busy", 256'(busy), 256'd1);
    for (int i = 0; i < MSG_BITS; i++) tick(1'b1, ks_arr[i], 1'b0, "restart_run");
    chk("mid_start_orig", 256'(result), 256'(orig));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
